// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard FSM state encoding, register-address width
// and the canonical NOP used when the front end is cleared.
package cpu_pkg;
  localparam int REG_AW = 5;
  localparam int MC_CW  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    MEM_WAIT = 2'd2,
    MEM_MC   = 2'd3
  } hz_state_e;
endpackage

// File: rtl/hazard_ctrl_detect.sv
// Combinational load-use comparator: the load in EX writes a register the
// instruction in ID reads. x0 never creates a dependency.
module hz_detect #(
  parameter int REG_AW = 5
) (
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  output logic              load_use_o
);
  assign load_use_o = idex_memread_i && (idex_rd_i != '0) &&
                      ((idex_rd_i == id_rs1_i) || (idex_rd_i == id_rs2_i));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: advance/hold/flush decisions for the front end,
// with an FSM sequencing multi-cycle EX ops and data-memory waits.
module hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic              branch_taken_i,
  input  logic              mc_start_i,
  input  logic              mem_busy_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              stall_select_o,
  output logic              flush_select_o,
  output logic              pipe_freeze_o,
  output logic              exmem_bubble_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  import cpu_pkg::*;

  hz_state_e          state_q, state_d;
  logic [MC_CW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               load_use;
  logic               mc_active;

  hz_detect #(.REG_AW(REG_AW)) u_detect (
    .idex_memread_i (idex_memread_i),
    .idex_rd_i      (idex_rd_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .load_use_o     (load_use)
  );

  // The cycle leaving MEM_MC behaves as an MC_WAIT cycle so a memory wait adds
  // exactly its own length to the multi-cycle hold.
  assign mc_active = (state_q == MC_WAIT) || (state_q == MEM_MC);

  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    stall_select_o = 1'b0;
    pipe_freeze_o  = 1'b0;
    exmem_bubble_o = 1'b0;
    state_d        = state_q;
    cnt_d          = cnt_q;
    if (mem_busy_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      pipe_freeze_o = 1'b1;
      state_d       = mc_active ? MEM_MC : MEM_WAIT;
    end else if (mc_active) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      exmem_bubble_o = 1'b1;
      cnt_d          = cnt_q - MC_CW'(1);
      state_d        = (cnt_q == MC_CW'(1)) ? RUN : MC_WAIT;
    end else begin
      state_d = RUN;
      if (load_use) begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        stall_select_o = 1'b1;
      end else if (branch_taken_i) begin
        ifid_flush_o = 1'b1;
      end
      if (mc_start_i) begin
        cnt_d   = MC_CW'(MC_LAT - 1);
        state_d = MC_WAIT;
      end
    end
  end

  assign flush_select_o = 1'b0;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed steps then random cycles, all checked
// against a remaining-hold-cycles reference model.
module tb_hazard_ctrl;
  localparam int MC_LAT = 4;
  localparam int AW     = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] rs1, rs2, rd;
  logic memread, br, mc, mb;

  logic pc_w, ifid_w, ifid_fl, st_sel, fl_sel, frz, bub;
  logic [15:0] scnt_o;
  logic pc_w4, ifid_w4, ifid_fl4, st_sel4, fl_sel4, frz4, bub4;
  logic [3:0] scnt4_o;

  int checks = 0;
  int errors = 0;
  int mc_rem = 0;
  int scnt = 0;
  int scnt4 = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MC_LAT(MC_LAT), .REG_AW(AW), .CNT_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .idex_memread_i(memread), .idex_rd_i(rd), .branch_taken_i(br),
    .mc_start_i(mc), .mem_busy_i(mb), .pc_write_o(pc_w), .ifid_write_o(ifid_w),
    .ifid_flush_o(ifid_fl), .stall_select_o(st_sel), .flush_select_o(fl_sel),
    .pipe_freeze_o(frz), .exmem_bubble_o(bub), .stall_cnt_o(scnt_o)
  );

  hazard_ctrl #(.MC_LAT(MC_LAT), .REG_AW(AW), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .idex_memread_i(memread), .idex_rd_i(rd), .branch_taken_i(br),
    .mc_start_i(mc), .mem_busy_i(mb), .pc_write_o(pc_w4), .ifid_write_o(ifid_w4),
    .ifid_flush_o(ifid_fl4), .stall_select_o(st_sel4), .flush_select_o(fl_sel4),
    .pipe_freeze_o(frz4), .exmem_bubble_o(bub4), .stall_cnt_o(scnt4_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int a1, input int a2, input bit ld, input int d,
                       input bit b, input bit m, input bit busy);
    rs1 = AW'(a1); rs2 = AW'(a2); memread = ld; rd = AW'(d);
    br = b; mc = m; mb = busy;
  endtask

  task automatic chk_defaults(input string tag);
    chk({tag, ".pc_write"}, 32'(pc_w), 1);
    chk({tag, ".ifid_write"}, 32'(ifid_w), 1);
    chk({tag, ".ifid_flush"}, 32'(ifid_fl), 0);
    chk({tag, ".stall_sel"}, 32'(st_sel), 0);
    chk({tag, ".freeze"}, 32'(frz), 0);
    chk({tag, ".bubble"}, 32'(bub), 0);
    chk({tag, ".stall_cnt"}, 32'(scnt_o), 0);
    chk({tag, ".stall_cnt4"}, 32'(scnt4_o), 0);
  endtask

  // One clock of stimulus: drive after the falling edge, compare the Mealy
  // outputs mid-cycle, then advance the model on the rising edge.
  task automatic step(input string tag, input int a1, input int a2, input bit ld,
                      input int d, input bit b, input bit m, input bit busy);
    bit lu, e_pc, e_fl, e_st, e_fz, e_bb;
    int nxt_rem;
    @(negedge clk);
    drive(a1, a2, ld, d, b, m, busy);
    #1;
    lu = ld && (d != 0) && (d == a1 || d == a2);
    e_pc = 1; e_fl = 0; e_st = 0; e_fz = 0; e_bb = 0;
    nxt_rem = mc_rem;
    if (busy) begin
      e_pc = 0; e_fz = 1;
    end else if (mc_rem > 0) begin
      e_pc = 0; e_bb = 1; nxt_rem = mc_rem - 1;
    end else begin
      if (lu) begin e_pc = 0; e_st = 1; end
      else if (b) e_fl = 1;
      if (m) nxt_rem = MC_LAT - 1;
    end
    chk({tag, ".pc_write"}, 32'(pc_w), 32'(e_pc));
    chk({tag, ".ifid_write"}, 32'(ifid_w), 32'(e_pc));
    chk({tag, ".ifid_flush"}, 32'(ifid_fl), 32'(e_fl));
    chk({tag, ".stall_sel"}, 32'(st_sel), 32'(e_st));
    chk({tag, ".flush_sel"}, 32'(fl_sel), 0);
    chk({tag, ".freeze"}, 32'(frz), 32'(e_fz));
    chk({tag, ".bubble"}, 32'(bub), 32'(e_bb));
    chk({tag, ".stall_cnt"}, 32'(scnt_o), 32'(scnt));
    chk({tag, ".stall_cnt4"}, 32'(scnt4_o), 32'(scnt4));
    @(posedge clk);
    mc_rem = nxt_rem;
    if (!e_pc) begin
      if (scnt < 65535) scnt++;
      if (scnt4 < 15) scnt4++;
    end
  endtask

  task automatic quiet(input string tag);
    step(tag, 1, 2, 0, 0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    chk_defaults("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step("lu", 0, 5, 1, 5, 0, 0, 0);
    quiet("lu_after");
    step("lu_rd0", 0, 0, 1, 0, 0, 0, 0);
    step("br", 1, 2, 0, 3, 1, 0, 0);
    quiet("br_after");
    step("br_lu", 0, 5, 1, 5, 1, 0, 0);
    step("br_retry", 0, 5, 0, 5, 1, 0, 0);

    step("mc_start", 1, 2, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) quiet("mc_hold");

    step("mcm_start", 1, 2, 0, 0, 0, 1, 0);
    quiet("mcm_hold1");
    step("mcm_busy", 1, 2, 0, 0, 0, 0, 1);
    step("mcm_busy", 1, 2, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) quiet("mcm_tail");

    step("rst_mc_start", 1, 2, 0, 0, 0, 1, 0);
    quiet("rst_mc_hold");
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_defaults("async_rst");
    mc_rem = 0; scnt = 0; scnt4 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet("post_rst");

    for (int i = 0; i < 20; i++) step("sat", 1, 2, 0, 0, 0, 0, 1);
    chk("sat4_final", 32'(scnt4_o), 15);
    quiet("sat_exit");

    for (int i = 0; i < 400; i++) begin
      step("rand",
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 1,
           $urandom_range(0, 19) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
